fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 33 +++
 rtl/fetch_ctrl_npc.sv | 41 ++++
 rtl/fetch_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared datapath constants: reset/NOP values, jump/branch opcodes, next-PC payload.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned IDX_W    = 26;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned OPCODE_W = 6;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_WORD     = 32'h0000_0000;

  // Compare-stage opcodes
  localparam logic [OPCODE_W-1:0] OP_BEQ     = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE     = 6'h05;
  // Jump decode: J/JAL primary opcodes, JR/JALR as SPECIAL funct codes
  localparam logic [OPCODE_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J       = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL     = 6'h03;
  localparam logic [OPCODE_W-1:0] FN_JR      = 6'h08;
  localparam logic [OPCODE_W-1:0] FN_JALR    = 6'h09;

  // Redirect request from the target generator
  typedef struct packed {
    logic            redirect;
    logic [XLEN-1:0] target;
  } npc_t;

  // Sign-extended word offset for a 16-bit branch immediate
  function automatic logic [XLEN-1:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_npc.sv
// Combinational redirect target generation: priority jr > jump > branch, gated by stall and id_valid.
module fetch_ctrl_npc
  import fetch_ctrl_pkg::*;
(
  input  logic                stall_i,
  input  logic                id_valid_i,
  input  logic                branch_i,
  input  logic                jump_i,
  input  logic                jr_i,
  input  logic [XLEN-1:0]     jr_addr_i,
  input  logic [XLEN-1:0]     pc4_id_i,
  input  logic [IDX_W-1:0]    ins_idx_i,
  output npc_t                npc_c_o
);

  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;
  logic [XLEN-1:0] jr_target;

  assign br_target = pc4_id_i + branch_offset(ins_idx_i[IMM_W-1:0]);
  assign j_target  = {pc4_id_i[XLEN-1:XLEN-4], ins_idx_i, 2'b00};
  assign jr_target = jr_addr_i & ~XLEN'(3);

  // Pick the highest-priority redirect; a bubble in ID never redirects
  always_comb begin
    npc_c_o = '0;
    if (!stall_i && id_valid_i) begin
      if (jr_i) begin
        npc_c_o.redirect = 1'b1;
        npc_c_o.target   = jr_target;
      end else if (jump_i) begin
        npc_c_o.redirect = 1'b1;
        npc_c_o.target   = j_target;
      end else if (branch_i) begin
        npc_c_o.redirect = 1'b1;
        npc_c_o.target   = br_target;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage: PC register and IF/ID pipeline register with stall hold and squashing redirects.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP      = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch,
  input  logic            jump,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_addr,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] ins_id,
  output logic [XLEN-1:0] pc4_id,
  output logic            id_valid
);

  logic [XLEN-1:0] pc_q,    pc_d;
  logic [XLEN-1:0] ins_q,   ins_d;
  logic [XLEN-1:0] pc4_q,   pc4_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_plus4;
  npc_t            npc;

  assign pc_plus4 = pc_q + XLEN'(4);

  fetch_ctrl_npc u_npc (
    .stall_i    (stall),
    .id_valid_i (valid_q),
    .branch_i   (branch),
    .jump_i     (jump),
    .jr_i       (jr),
    .jr_addr_i  (jr_addr),
    .pc4_id_i   (pc4_q),
    .ins_idx_i  (ins_q[IDX_W-1:0]),
    .npc_c_o    (npc)
  );

  // Next state: hold on stall, squash on redirect, otherwise advance sequentially
  always_comb begin
    pc_d    = pc_q;
    ins_d   = ins_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!stall) begin
      if (npc.redirect) begin
        pc_d    = npc.target;
        ins_d   = NOP;
        pc4_d   = '0;
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_plus4;
        ins_d   = imem_data;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  // PC and IF/ID registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      ins_q   <= NOP;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ins_id    = ins_q;
  assign pc4_id    = pc4_q;
  assign id_valid  = valid_q;

endmodule
